// File: rtl/game_ctrl.sv
// Tic-tac-toe sequencer: turns mouse clicks into cell claims and detects wins and draws.
// Optional macro GAME_CTRL_SCORE_EN adds saturating per-player win counters.
//
// state | meaning
// PLAY  | waiting for a click on a free cell
// CHECK | one cycle: evaluate the mover's lines and the full-board condition
// WIN   | mover completed a line; board frozen until new_game
// DRAW  | board full without a line; frozen until new_game
module game_ctrl #(
  parameter logic [11:0] C0_END = 12'd338,
  parameter logic [11:0] C1_BEG = 12'd344,
  parameter logic [11:0] C1_END = 12'd679,
  parameter logic [11:0] C2_BEG = 12'd685,
  parameter logic [11:0] C2_END = 12'd1023,
  parameter logic [11:0] R0_END = 12'd251,
  parameter logic [11:0] R1_BEG = 12'd259,
  parameter logic [11:0] R1_END = 12'd507,
  parameter logic [11:0] R2_BEG = 12'd515,
  parameter logic [11:0] R2_END = 12'd767
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic        new_game,
  output logic [8:0]  board_x,
  output logic [8:0]  board_o,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [1:0]  winner,
  output logic [8:0]  win_mask
`ifdef GAME_CTRL_SCORE_EN
  ,
  output logic [3:0]  score_x,
  output logic [3:0]  score_o
`endif
);

  typedef enum logic [1:0] {PLAY = 2'b00, CHECK = 2'b01, WIN = 2'b10, DRAW = 2'b11} state_t;

  // Lines in priority order, line 0 in the low 9 bits: rows, columns, then the two diagonals.
  localparam logic [71:0] LINES = {9'h054, 9'h111, 9'h124, 9'h092, 9'h049,
                                   9'h1C0, 9'h038, 9'h007};

  state_t      state, state_nx;
  logic        mouse_left_d, click;
  logic [1:0]  col, row;
  logic        col_ok, row_ok, cell_ok;
  logic [3:0]  cell_idx;
  logic [8:0]  cell_bit, mover_mask, line_sel;
  logic        line_hit;
  logic [8:0]  board_x_nx, board_o_nx, win_mask_nx;
  logic        turn_nx;
  logic [1:0]  winner_nx;
`ifdef GAME_CTRL_SCORE_EN
  logic [3:0]  score_x_nx, score_o_nx;
`endif

  assign click      = mouse_left & ~mouse_left_d;
  assign game_state = state;
  assign mover_mask = turn ? board_o : board_x;

  always_comb begin
    col    = 2'd0;
    col_ok = 1'b1;
    if (xpos <= C0_END)                        col = 2'd0;
    else if (xpos >= C1_BEG && xpos <= C1_END) col = 2'd1;
    else if (xpos >= C2_BEG && xpos <= C2_END) col = 2'd2;
    else                                       col_ok = 1'b0;
    row    = 2'd0;
    row_ok = 1'b1;
    if (ypos <= R0_END)                        row = 2'd0;
    else if (ypos >= R1_BEG && ypos <= R1_END) row = 2'd1;
    else if (ypos >= R2_BEG && ypos <= R2_END) row = 2'd2;
    else                                       row_ok = 1'b0;
    cell_ok  = col_ok & row_ok;
    cell_idx = 4'(row) * 4'd3 + 4'(col);
    cell_bit = 9'(1) << cell_idx;
  end

  // Scanning from the last line down leaves the first complete line selected.
  always_comb begin
    line_hit = 1'b0;
    line_sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if ((mover_mask & LINES[i*9 +: 9]) == LINES[i*9 +: 9]) begin
        line_hit = 1'b1;
        line_sel = LINES[i*9 +: 9];
      end
    end
  end

  always_comb begin
    state_nx    = state;
    board_x_nx  = board_x;
    board_o_nx  = board_o;
    turn_nx     = turn;
    winner_nx   = winner;
    win_mask_nx = win_mask;
`ifdef GAME_CTRL_SCORE_EN
    score_x_nx  = score_x;
    score_o_nx  = score_o;
`endif
    if (new_game) begin
      state_nx    = PLAY;
      board_x_nx  = '0;
      board_o_nx  = '0;
      turn_nx     = 1'b0;
      winner_nx   = 2'b00;
      win_mask_nx = '0;
    end else begin
      case (state)
        PLAY: begin
          if (click && cell_ok && ((board_x | board_o) & cell_bit) == 9'h000) begin
            if (turn) board_o_nx = board_o | cell_bit;
            else      board_x_nx = board_x | cell_bit;
            state_nx = CHECK;
          end
        end
        CHECK: begin
          if (line_hit) begin
            state_nx    = WIN;
            winner_nx   = turn ? 2'b10 : 2'b01;
            win_mask_nx = line_sel;
`ifdef GAME_CTRL_SCORE_EN
            if (!turn && score_x != 4'hF) score_x_nx = score_x + 4'd1;
            if (turn && score_o != 4'hF)  score_o_nx = score_o + 4'd1;
`endif
          end else if ((board_x | board_o) == 9'h1FF) begin
            state_nx = DRAW;
          end else begin
            state_nx = PLAY;
            turn_nx  = ~turn;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state        <= PLAY;
      mouse_left_d <= 1'b0;
      board_x      <= '0;
      board_o      <= '0;
      turn         <= 1'b0;
      winner       <= 2'b00;
      win_mask     <= '0;
`ifdef GAME_CTRL_SCORE_EN
      score_x      <= '0;
      score_o      <= '0;
`endif
    end else begin
      state        <= state_nx;
      mouse_left_d <= mouse_left;
      board_x      <= board_x_nx;
      board_o      <= board_o_nx;
      turn         <= turn_nx;
      winner       <= winner_nx;
      win_mask     <= win_mask_nx;
`ifdef GAME_CTRL_SCORE_EN
      score_x      <= score_x_nx;
      score_o      <= score_o_nx;
`endif
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed games plus random clicks, checked against a rules-level game model.
module tb_game_ctrl;

  typedef struct packed {
    logic [8:0] bx;
    logic [8:0] bo;
    logic       t;
    logic [1:0] st;
    logic [1:0] win;
    logic [8:0] wm;
    logic [3:0] sx;
    logic [3:0] so;
  } snap_t;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        mouse_left = 1'b0;
  logic        new_game = 1'b0;
  logic [8:0]  board_x, board_o, win_mask;
  logic        turn;
  logic [1:0]  game_state, winner;
`ifdef GAME_CTRL_SCORE_EN
  logic [3:0]  score_x, score_o;
`endif

  game_ctrl dut (
    .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .mouse_left(mouse_left), .new_game(new_game),
    .board_x(board_x), .board_o(board_o), .turn(turn),
    .game_state(game_state), .winner(winner), .win_mask(win_mask)
`ifdef GAME_CTRL_SCORE_EN
    , .score_x(score_x), .score_o(score_o)
`endif
  );

  always #5 pclk = ~pclk;

  // reference model: game rules in terms of cell sets
  logic [8:0] m_bx, m_bo, m_wm;
  logic       m_turn;
  int         m_state;   // 0 PLAY, 1 CHECK, 2 WIN, 3 DRAW (output encoding)
  int         m_winner;
  int         m_sx, m_so;
  int         ln [8][3];

  snap_t q[$];
  bit    chk = 1'b0;
  int    total = 0;
  int    bad = 0;

  function automatic int col_of(int x);
    if (x <= 338) return 0;
    if (x >= 344 && x <= 679) return 1;
    if (x >= 685 && x <= 1023) return 2;
    return -1;
  endfunction

  function automatic int row_of(int y);
    if (y <= 251) return 0;
    if (y >= 259 && y <= 507) return 1;
    if (y >= 515 && y <= 767) return 2;
    return -1;
  endfunction

  function automatic int cell_of(int x, int y);
    int c, r;
    c = col_of(x);
    r = row_of(y);
    if (c < 0 || r < 0) return -1;
    return r * 3 + c;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.bx = m_bx; s.bo = m_bo; s.t = m_turn;
    s.st = 2'(m_state); s.win = 2'(m_winner); s.wm = m_wm;
    s.sx = 4'(m_sx); s.so = 4'(m_so);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.bx = board_x; s.bo = board_o; s.t = turn;
    s.st = game_state; s.win = winner; s.wm = win_mask;
`ifdef GAME_CTRL_SCORE_EN
    s.sx = score_x; s.so = score_o;
`else
    s.sx = 4'd0; s.so = 4'd0;
`endif
    return s;
  endfunction

  task automatic model_clear();
    m_bx = '0; m_bo = '0; m_wm = '0; m_turn = 1'b0; m_state = 0; m_winner = 0;
  endtask

  task automatic model_resolve();
    logic [8:0] mine;
    bit found;
    mine  = m_turn ? m_bo : m_bx;
    found = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if (!found && mine[ln[l][0]] && mine[ln[l][1]] && mine[ln[l][2]]) begin
        found = 1'b1;
        m_wm = '0;
        for (int k = 0; k < 3; k++) m_wm[ln[l][k]] = 1'b1;
      end
    end
    if (found) begin
      m_state  = 2;
      m_winner = m_turn ? 2 : 1;
`ifdef GAME_CTRL_SCORE_EN
      if (m_turn) begin if (m_so < 15) m_so++; end
      else        begin if (m_sx < 15) m_sx++; end
`endif
    end else if ((m_bx | m_bo) == 9'h1FF) begin
      m_state = 3;
    end else begin
      m_state = 0;
      m_turn  = ~m_turn;
    end
  endtask

  task automatic expect_now(input string name);
    q.push_back(model_snap());
    chk = 1'b1;
    @(negedge pclk);
    #1 chk = 1'b0;
  endtask

  always @(negedge pclk) begin
    if (chk) begin
      snap_t e, a;
      total++;
      a = dut_snap();
      if (q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL snapshot at %0t: got bx=%h bo=%h t=%0d st=%0d win=%0d wm=%h sx=%0d so=%0d want bx=%h bo=%h t=%0d st=%0d win=%0d wm=%h sx=%0d so=%0d",
                   $time, a.bx, a.bo, a.t, a.st, a.win, a.wm, a.sx, a.so,
                   e.bx, e.bo, e.t, e.st, e.win, e.wm, e.sx, e.so);
        end
      end
    end
  end

  // Button held for 'hold' cycles (>=2); checks the CHECK cycle when a claim happens, then the settled result.
  task automatic press(input int x, input int y, input int hold);
    int  c;
    bit  claim;
    @(posedge pclk); #1;
    xpos = 12'(x); ypos = 12'(y); mouse_left = 1'b1;
    c = cell_of(x, y);
    claim = (m_state == 0) && (c >= 0) && !m_bx[c] && !m_bo[c];
    @(posedge pclk); #1;
    if (claim) begin
      if (m_turn) m_bo[c] = 1'b1; else m_bx[c] = 1'b1;
      m_state = 1;
      expect_now("check_cycle");
    end
    @(posedge pclk); #1;
    if (claim) model_resolve();
    expect_now("after_click");
    repeat (hold - 2) @(posedge pclk);
    #1 mouse_left = 1'b0;
    repeat (2) @(posedge pclk);
    #1 expect_now("after_release");
  endtask

  task automatic play_cell(input int c, input int hold);
    int xs[3] = '{100, 500, 850};
    int ys[3] = '{100, 380, 640};
    press(xs[c % 3], ys[c / 3], hold);
  endtask

  task automatic start_new_game(input bit with_click);
    @(posedge pclk); #1;
    new_game = 1'b1;
    if (with_click) begin xpos = 12'd850; ypos = 12'd640; mouse_left = 1'b1; end
    @(posedge pclk); #1;
    new_game = 1'b0;
    model_clear();
    expect_now("new_game");
    if (with_click) begin
      @(posedge pclk); #1;
      mouse_left = 1'b0;
      @(posedge pclk); #1;
      expect_now("held_after_new_game");
    end
  endtask

  task automatic random_press();
    int x, y, cc, rr;
    if ($urandom_range(0, 9) < 8) begin
      cc = $urandom_range(0, 2);
      rr = $urandom_range(0, 2);
      x = (cc == 0) ? $urandom_range(0, 338) : (cc == 1) ? $urandom_range(344, 679) : $urandom_range(685, 1023);
      y = (rr == 0) ? $urandom_range(0, 251) : (rr == 1) ? $urandom_range(259, 507) : $urandom_range(515, 767);
    end else begin
      x = $urandom_range(0, 4095);
      y = $urandom_range(0, 4095);
    end
    press(x, y, $urandom_range(2, 4));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < 3; r++) begin
      ln[r][0] = r * 3; ln[r][1] = r * 3 + 1; ln[r][2] = r * 3 + 2;
      ln[3 + r][0] = r; ln[3 + r][1] = r + 3; ln[3 + r][2] = r + 6;
    end
    ln[6][0] = 0; ln[6][1] = 4; ln[6][2] = 8;
    ln[7][0] = 2; ln[7][1] = 4; ln[7][2] = 6;
    model_clear();
    m_sx = 0; m_so = 0;

    repeat (3) @(posedge pclk);
    #1 expect_now("reset_state");
    rst = 1'b0;

    press(100, 100, 5);
    press(500, 100, 2);
    press(500, 100, 2);

    start_new_game(1'b0);
    play_cell(0, 2); play_cell(3, 2); play_cell(1, 3); play_cell(4, 2); play_cell(2, 2);
    play_cell(8, 2); play_cell(5, 3);

    start_new_game(1'b0);
    play_cell(0, 2); play_cell(1, 2); play_cell(2, 2); play_cell(4, 2); play_cell(3, 2);
    play_cell(5, 2); play_cell(7, 2); play_cell(6, 2); play_cell(8, 2);
    play_cell(0, 2);

    start_new_game(1'b0);
    press(340, 100, 2);
    press(100, 255, 2);
    press(1024, 100, 2);
    press(100, 768, 2);
    start_new_game(1'b1);

    play_cell(4, 2); play_cell(0, 2);
    @(posedge pclk); #1;
    rst = 1'b1;
    model_clear();
    m_sx = 0; m_so = 0;
    expect_now("async_reset");
    #2 rst = 1'b0;

`ifdef GAME_CTRL_SCORE_EN
    for (int g = 0; g < 16; g++) begin
      start_new_game(1'b0);
      play_cell(0, 2); play_cell(3, 2); play_cell(1, 2); play_cell(4, 2); play_cell(2, 2);
    end
    start_new_game(1'b0);
    play_cell(0, 2); play_cell(3, 2); play_cell(1, 2); play_cell(4, 2); play_cell(8, 2); play_cell(5, 2);
    @(posedge pclk); #1;
    rst = 1'b1;
    model_clear();
    m_sx = 0; m_so = 0;
    expect_now("score_reset");
    #2 rst = 1'b0;
`endif

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 11) == 0) start_new_game($urandom_range(0, 1) == 1);
      else random_press();
    end

    repeat (2) @(posedge pclk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
